// File: rtl/c7b_store_buf.sv
// -----------------------------------------------------------------------------
// c7b_store_buf
//   Posted-write store buffer between the LSU write port and the BIU write
//   request port. Single-beat word stores are accepted in one cycle, queued in
//   a DEPTH-entry FIFO and drained one at a time to the BIU. Each drain uses a
//   request/ack handshake and then waits for the write-done response. A load
//   address can be checked against every queued or in-flight store.
//
// Parameters
//   DEPTH : FIFO entries (power of two, 2..16)
//   AW    : address width
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   lsu_sb_wr_req/addr/data/strb, sb_lsu_wr_ack
//                           LSU store port; the store is accepted while ack=1
//   lsu_sb_rd_check/addr, sb_lsu_rd_hazard
//                           load hazard check against valid entries (word match)
//   sb_biu_wr_req/addr/data/strb, biu_sb_wr_ack, biu_sb_write_done
//                           BIU write request presenting the head entry
//   sb_empty, sb_full, sb_count
//                           occupancy, derived from the registered count
//
// Build option
//   SB_MERGE_EN : when defined, a store to the same word as the youngest entry
//                 is merged into it (unless that entry is the head and is
//                 being issued to the BIU). Undefined: every store allocates.
// -----------------------------------------------------------------------------
module c7b_store_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  // LSU store port
  input  logic                    lsu_sb_wr_req,
  input  logic [AW-1:0]           lsu_sb_wr_addr,
  input  logic [31:0]             lsu_sb_wr_data,
  input  logic [3:0]              lsu_sb_wr_strb,
  output logic                    sb_lsu_wr_ack,
  // LSU load hazard check
  input  logic                    lsu_sb_rd_check,
  input  logic [AW-1:0]           lsu_sb_rd_addr,
  output logic                    sb_lsu_rd_hazard,
  // BIU write port
  output logic                    sb_biu_wr_req,
  output logic [AW-1:0]           sb_biu_wr_addr,
  output logic [31:0]             sb_biu_wr_data,
  output logic [3:0]              sb_biu_wr_strb,
  input  logic                    biu_sb_wr_ack,
  input  logic                    biu_sb_write_done,
  // Status
  output logic                    sb_empty,
  output logic                    sb_full,
  output logic [$clog2(DEPTH):0]  sb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = AW - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Control state (reset)
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  // Entry storage (not reset; validity comes from head/count)
  logic [WA_W-1:0]  ent_waddr [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [3:0]       ent_strb  [DEPTH];

  logic [DEPTH-1:0] ent_vld;
  logic             full;
  logic             empty;
  logic             push;
  logic             alloc;
  logic             pop;
  logic             merge_hit;
  logic             hazard_any;

  // Byte offsets are irrelevant: entries and hazard checks work on word addresses.
  logic             unused_low_bits;
  assign unused_low_bits = ^{lsu_sb_wr_addr[1:0], lsu_sb_rd_addr[1:0]};

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

`ifdef SB_MERGE_EN
  logic [PTR_W-1:0] last;

  // Byte-lane merge of new store data over an existing entry.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                              input logic [31:0] new_d,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_d;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_d[8*b +: 8];
    end
    return res;
  endfunction

  assign last = tail - PTR_W'(1);

  // The youngest entry may absorb the store unless it is the head currently
  // owned by the BIU handshake (its contents must stay stable until done).
  assign merge_hit = !empty &&
                     (ent_waddr[last] == lsu_sb_wr_addr[AW-1:2]) &&
                     !((last == head) && (state != S_IDLE));
`else
  assign merge_hit = 1'b0;
`endif

  // A merge needs no free slot, so it is accepted even when full.
  assign sb_lsu_wr_ack = lsu_sb_wr_req & (~full | merge_hit);
  assign push          = sb_lsu_wr_ack;
  assign alloc         = push & ~merge_hit;

  // The head leaves only when its write-done is seen during the handshake.
  assign pop = ((state == S_REQ)  && biu_sb_wr_ack && biu_sb_write_done) ||
               ((state == S_WAIT) && biu_sb_write_done);

  // Entry i is valid when its distance from head is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    ent_vld = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - head;
      ent_vld[i] = ({1'b0, off} < count);
    end
  end

  always_comb begin
    hazard_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_waddr[i] == lsu_sb_rd_addr[AW-1:2])) hazard_any = 1'b1;
    end
  end

  assign sb_lsu_rd_hazard = lsu_sb_rd_check & hazard_any;

  // Drain FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!empty) state_nxt = S_REQ;
      S_REQ: begin
        if (biu_sb_wr_ack) begin
          if (biu_sb_write_done) state_nxt = S_IDLE;
          else                   state_nxt = S_WAIT;
        end
      end
      S_WAIT: if (biu_sb_write_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (pop)   head <= head + PTR_W'(1);
      if (alloc) tail <= tail + PTR_W'(1);
      case ({alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_waddr[tail] <= lsu_sb_wr_addr[AW-1:2];
      ent_data[tail]  <= lsu_sb_wr_data;
      ent_strb[tail]  <= lsu_sb_wr_strb;
    end
`ifdef SB_MERGE_EN
    else if (push) begin
      ent_data[last] <= merge_bytes(ent_data[last], lsu_sb_wr_data, lsu_sb_wr_strb);
      ent_strb[last] <= ent_strb[last] | lsu_sb_wr_strb;
    end
`endif
  end

  // BIU outputs: head fields are masked to zero while empty so nothing stale
  // (or uninitialised after reset) is ever presented.
  assign sb_biu_wr_req  = (state == S_REQ);
  assign sb_biu_wr_addr = empty ? '0 : {ent_waddr[head], 2'b00};
  assign sb_biu_wr_data = empty ? '0 : ent_data[head];
  assign sb_biu_wr_strb = empty ? '0 : ent_strb[head];

  assign sb_empty = empty;
  assign sb_full  = full;
  assign sb_count = count;

endmodule

// File: tb/tb_c7b_store_buf.sv
// -----------------------------------------------------------------------------
// tb_c7b_store_buf
//   Directed scenarios followed by randomized traffic. A queue-based model of
//   the store buffer predicts every output each cycle; directed steps add
//   explicit expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_c7b_store_buf;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic          wr_ack;
  logic          rd_check;
  logic [AW-1:0] rd_addr;
  logic          hazard;
  logic          b_req;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_data;
  logic [3:0]    b_strb;
  logic          b_ack;
  logic          b_done;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;

  c7b_store_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .lsu_sb_wr_req     (wr_req),
    .lsu_sb_wr_addr    (wr_addr),
    .lsu_sb_wr_data    (wr_data),
    .lsu_sb_wr_strb    (wr_strb),
    .sb_lsu_wr_ack     (wr_ack),
    .lsu_sb_rd_check   (rd_check),
    .lsu_sb_rd_addr    (rd_addr),
    .sb_lsu_rd_hazard  (hazard),
    .sb_biu_wr_req     (b_req),
    .sb_biu_wr_addr    (b_addr),
    .sb_biu_wr_data    (b_data),
    .sb_biu_wr_strb    (b_strb),
    .biu_sb_wr_ack     (b_ack),
    .biu_sb_write_done (b_done),
    .sb_empty          (empty),
    .sb_full           (full),
    .sb_count          (count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } ent_t;

  ent_t q[$];          // model contents, oldest first
  ent_t issued[$];     // stores seen accepted by the BIU
  int   phase;         // 0: not requesting, 1: request shown, 2: awaiting done
  bit   model_on;
  int   n_assert;
  int   n_fail;
  logic seen_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_merge();
`ifdef SB_MERGE_EN
    if (q.size() == 0) return 1'b0;
    if (q[q.size()-1].addr[AW-1:2] != wr_addr[AW-1:2]) return 1'b0;
    if (q.size() == 1 && phase != 0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: check all outputs on the falling edge, then advance the model.
  task automatic cycle();
    bit   e_mrg, e_ack, e_haz, pop;
    int   sz0;
    ent_t h, t;
    @(negedge clk);
    e_mrg = wr_req && m_merge();
    e_ack = wr_req && ((q.size() < DEPTH) || e_mrg);
    e_haz = 1'b0;
    foreach (q[i]) if (rd_check && q[i].addr[AW-1:2] == rd_addr[AW-1:2]) e_haz = 1'b1;
    if (q.size() != 0) h = q[0];
    else begin h.addr = '0; h.data = '0; h.strb = '0; end
    seen_ack = wr_ack;
    if (model_on) begin
      chk("wr_ack",   64'(wr_ack), 64'(e_ack));
      chk("hazard",   64'(hazard), 64'(e_haz));
      chk("biu_req",  64'(b_req),  64'(phase == 1));
      chk("biu_addr", 64'(b_addr), 64'(h.addr));
      chk("biu_data", 64'(b_data), 64'(h.data));
      chk("biu_strb", 64'(b_strb), 64'(h.strb));
      chk("count",    64'(count),  64'(q.size()));
      chk("empty",    64'(empty),  64'(q.size() == 0));
      chk("full",     64'(full),   64'(q.size() == DEPTH));
    end
    if (b_req && b_ack) begin
      t.addr = b_addr; t.data = b_data; t.strb = b_strb;
      issued.push_back(t);
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      phase = 0;
    end else begin
      sz0 = q.size();
      pop = (phase == 1 && b_ack && b_done) || (phase == 2 && b_done);
      if (pop) void'(q.pop_front());
      if (e_ack) begin
        if (e_mrg) begin
          t = q[q.size()-1];
          for (int b = 0; b < 4; b++) if (wr_strb[b]) t.data[8*b +: 8] = wr_data[8*b +: 8];
          t.strb = t.strb | wr_strb;
          q[q.size()-1] = t;
        end else begin
          t.addr = {wr_addr[AW-1:2], 2'b00}; t.data = wr_data; t.strb = wr_strb;
          q.push_back(t);
        end
      end
      case (phase)
        0: if (sz0 != 0) phase = 1;
        1: if (b_ack) phase = b_done ? 0 : 2;
        2: if (b_done) phase = 0;
        default: phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic push_hold(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int max_cyc);
    bit got;
    got = 1'b0;
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    for (int i = 0; i < max_cyc && !got; i++) begin
      cycle();
      if (seen_ack) got = 1'b1;
    end
    wr_req = 1'b0;
    chk("push_ack_bound", 64'(got), 64'(1));
  endtask

  task automatic wait_req(input int max_cyc);
    bit got;
    got = b_req;
    for (int i = 0; i < max_cyc && !got; i++) begin
      cycle();
      if (b_req) got = 1'b1;
    end
    chk("wait_req_bound", 64'(got), 64'(1));
  endtask

  task automatic drain(input int max_cyc);
    bit got;
    got = 1'b0;
    b_ack = 1'b1; b_done = 1'b1;
    for (int i = 0; i < max_cyc && !got; i++) begin
      cycle();
      if (empty) got = 1'b1;
    end
    b_ack = 1'b0; b_done = 1'b0;
    chk("drain_bound", 64'(got), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] exp_addr[$];
    int            n;
    n_assert = 0; n_fail = 0; model_on = 1'b0; phase = 0;
    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_check = 1'b0; rd_addr = '0; b_ack = 1'b0; b_done = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    model_on = 1'b1;

    // Reset values
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full",  64'(full),  64'(0));
    chk("rst_req",   64'(b_req), 64'(0));
    chk("rst_ack",   64'(wr_ack), 64'(0));
    chk("rst_addr",  64'(b_addr), 64'(0));

    // Single store: ack same cycle, request two cycles later, drained after done
    wr_req = 1'b1; wr_addr = 32'h1000; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
    #1 chk("t1_ack_same_cycle", 64'(wr_ack), 64'(1));
    cycle();
    wr_req = 1'b0;
    chk("t1_req_plus1", 64'(b_req), 64'(0));
    cycle();
    chk("t1_req_plus2", 64'(b_req), 64'(1));
    chk("t1_addr", 64'(b_addr), 64'(32'h1000));
    chk("t1_data", 64'(b_data), 64'(32'hDEADBEEF));
    b_ack = 1'b1; b_done = 1'b1;
    cycle();
    b_ack = 1'b0; b_done = 1'b0;
    chk("t1_empty", 64'(empty), 64'(1));
    chk("t1_count", 64'(count), 64'(0));

    // Fill while the BIU withholds ack; the fifth store waits for a slot
    for (int i = 0; i < 4; i++) push_hold(32'h100 + 32'(4*i), 32'hA0 + 32'(i), 4'hF, 3);
    wr_req = 1'b1; wr_addr = 32'h110; wr_data = 32'hA4; wr_strb = 4'hF;
    cycle();
    chk("t2_fifth_held", 64'(seen_ack), 64'(0));
    chk("t2_full", 64'(full), 64'(1));
    cycle();
    chk("t2_fifth_still_held", 64'(seen_ack), 64'(0));
    b_ack = 1'b1; b_done = 1'b1;
    cycle();
    b_ack = 1'b0; b_done = 1'b0;
    #1 chk("t2_fifth_ack_after_done", 64'(wr_ack), 64'(1));
    cycle();
    wr_req = 1'b0;
    chk("t2_count_after", 64'(count), 64'(4));
    drain(40);

    // Hazard tracking through request, wait and completion
    push_hold(32'h2004, 32'h12345678, 4'hF, 3);
    rd_check = 1'b1; rd_addr = 32'h2006;
    #1 chk("t3_hazard_hit", 64'(hazard), 64'(1));
    rd_addr = 32'h2008;
    #1 chk("t3_hazard_miss", 64'(hazard), 64'(0));
    rd_addr = 32'h2004;
    wait_req(5);
    b_ack = 1'b1;
    cycle();
    b_ack = 1'b0;
    chk("t3_wait_no_req", 64'(b_req), 64'(0));
    chk("t3_hazard_wait", 64'(hazard), 64'(1));
    cycle();
    chk("t3_hazard_wait2", 64'(hazard), 64'(1));
    b_done = 1'b1;
    cycle();
    b_done = 1'b0;
    chk("t3_hazard_drop", 64'(hazard), 64'(0));
    rd_check = 1'b0;

    // FIFO order with ack+done together, pointers wrapping over two laps
    issued.delete();
    exp_addr.delete();
    n = 0;
    for (int lap = 0; lap < 3; lap++) begin
      for (int k = 0; k < ((lap < 2) ? 3 : 2); k++) begin
        push_hold(32'h7000 + 32'(16*n), 32'h7000_0000 + 32'(n), 4'hF, 3);
        exp_addr.push_back(32'h7000 + 32'(16*n));
        n++;
      end
      drain(30);
    end
    chk("t4_issued_count", 64'(issued.size()), 64'(8));
    for (int i = 0; i < 8 && i < issued.size(); i++)
      chk("t4_order", 64'(issued[i].addr), 64'(exp_addr[i]));

    // Same-word stores behind a busy head
    issued.delete();
    push_hold(32'h4000, 32'hAAAA_AAAA, 4'hF, 3);
    wait_req(5);
    push_hold(32'h3000, 32'h0000_0011, 4'h1, 3);
    push_hold(32'h3000, 32'h0022_0000, 4'h4, 3);
`ifdef SB_MERGE_EN
    chk("t5_count_merged", 64'(count), 64'(2));
`else
    chk("t5_count_alloc", 64'(count), 64'(3));
`endif
    drain(30);
`ifdef SB_MERGE_EN
    chk("t5_n_issued", 64'(issued.size()), 64'(2));
    if (issued.size() >= 2) begin
      chk("t5_m_addr", 64'(issued[1].addr), 64'(32'h3000));
      chk("t5_m_strb", 64'(issued[1].strb), 64'(4'h5));
      chk("t5_m_data", 64'(issued[1].data), 64'(32'h0022_0011));
    end
`else
    chk("t5_n_issued", 64'(issued.size()), 64'(3));
    if (issued.size() >= 3) begin
      chk("t5_a_strb", 64'(issued[1].strb), 64'(4'h1));
      chk("t5_a_data", 64'(issued[1].data), 64'(32'h0000_0011));
      chk("t5_b_strb", 64'(issued[2].strb), 64'(4'h4));
      chk("t5_b_data", 64'(issued[2].data), 64'(32'h0022_0000));
    end
`endif

    // Reset while waiting for write-done with three entries queued
    push_hold(32'h5000, 32'h1, 4'hF, 3);
    push_hold(32'h5004, 32'h2, 4'hF, 3);
    push_hold(32'h5008, 32'h3, 4'hF, 3);
    wait_req(5);
    b_ack = 1'b1;
    cycle();
    b_ack = 1'b0;
    chk("t6_in_wait", 64'(b_req), 64'(0));
    chk("t6_count_before", 64'(count), 64'(3));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t6_count_reset", 64'(count), 64'(0));
    chk("t6_req_reset", 64'(b_req), 64'(0));
    b_done = 1'b1;
    cycle();
    b_done = 1'b0;
    cycle();
    chk("t6_done_ignored_count", 64'(count), 64'(0));
    chk("t6_done_ignored_req", 64'(b_req), 64'(0));

    // Randomized traffic over a small address pool
    for (int c = 0; c < 800; c++) begin
      wr_req   = 1'($urandom_range(0, 1));
      wr_addr  = 32'h6000 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3));
      wr_data  = $urandom;
      wr_strb  = 4'($urandom_range(0, 15));
      rd_check = 1'($urandom_range(0, 1));
      rd_addr  = 32'h6000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      b_ack    = ($urandom_range(0, 9) < 4);
      b_done   = ($urandom_range(0, 9) < 3);
      cycle();
    end
    wr_req = 1'b0; rd_check = 1'b0;
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
